// File: rtl/shreg_ctrl_pkg.sv
// shreg_ctrl_pkg: shared types and helpers for the RAM delay-line sequencer.
// SHREG_CTRL_BYPASS_EN lowers the minimum delay from 2 to 1.
package shreg_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
`ifdef SHREG_CTRL_BYPASS_EN
   localparam int DMIN = 1;
`else
   localparam int DMIN = 2;
`endif
   function automatic int clamp_delay(input int d, input int wdepth);
      return (d > wdepth) ? wdepth : (d < DMIN) ? DMIN : d;
   endfunction
   function automatic int mod_sub(input int a, input int b, input int m);
      return (a >= b) ? a - b : a - b + m;
   endfunction
endpackage

// File: rtl/mod_ptr.sv
// mod_ptr: modulo-M up-counter with enable, used as the RAM write pointer.
// Behaviour does not depend on SHREG_CTRL_BYPASS_EN.
module mod_ptr #(
   parameter int M = 10,
   parameter int AW = $clog2(M)
) (
   input  logic          clk,
   input  logic          Reset_n,
   input  logic          en,
   output logic [AW-1:0] cnt
);
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) cnt <= '0;
      else if (en) cnt <= (cnt == AW'(M - 1)) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ram_shift_reg_ctrl.sv
// ram_shift_reg_ctrl: drives a 1R1W RAM as a circular buffer so dout(t)=din(t-D).
// Define SHREG_CTRL_BYPASS_EN to allow D=1 through a din->dout register.
module ram_shift_reg_ctrl
   import shreg_ctrl_pkg::*;
#(
   parameter int DSIZE = 6,
   parameter int WDEPTH = 10,
   parameter int DEF_DELAY = 4,
   localparam int AW = $clog2(WDEPTH),
   localparam int DW = $clog2(WDEPTH + 1)
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             en,
   input  logic [DSIZE-1:0] din,
   input  logic             cfg_load,
   input  logic [DW-1:0]    cfg_delay,
   output logic             ram_we,
   output logic [AW-1:0]    ram_waddr,
   output logic [DSIZE-1:0] ram_wdata,
   output logic             ram_re,
   output logic [AW-1:0]    ram_raddr,
   input  logic [DSIZE-1:0] ram_rdata,
   output logic [DSIZE-1:0] dout,
   output logic             dout_valid,
   output logic             cfg_err
);
   localparam logic [DW-1:0] D_RST = DW'(clamp_delay(DEF_DELAY, WDEPTH));
   state_t state, state_nx;
   logic [DW-1:0] d, d_clamp, fill_cnt;
   logic [AW-1:0] wp;
   mod_ptr #(.M(WDEPTH), .AW(AW)) u_wp (.clk(clk), .Reset_n(Reset_n), .en(en), .cnt(wp));
   assign d_clamp = DW'(clamp_delay(int'(cfg_delay), WDEPTH));
   assign ram_we = en;
   assign ram_re = en;
   assign ram_waddr = wp;
   assign ram_wdata = din;
   assign ram_raddr = AW'(mod_sub(int'(wp), int'(d) - 1, WDEPTH));
   assign dout_valid = (state == RUN);
   // The read issued at fill_cnt==D-1 fetches sample 0, so RUN lines up with its data.
   always_comb begin
      state_nx = state;
      if (cfg_load) state_nx = FILL;
      else if (en && state != RUN) state_nx = (fill_cnt == d - 1'b1) ? RUN : FILL;
   end
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) begin
         state <= IDLE;
         d <= D_RST;
         fill_cnt <= '0;
         cfg_err <= 1'b0;
      end else begin
         state <= state_nx;
         cfg_err <= cfg_load && (d_clamp != cfg_delay);
         if (cfg_load) begin
            d <= d_clamp;
            fill_cnt <= '0;
         end else if (en && state != RUN) fill_cnt <= fill_cnt + 1'b1;
      end
`ifdef SHREG_CTRL_BYPASS_EN
   logic [DSIZE-1:0] byp;
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) byp <= '0;
      else if (en) byp <= din;
   assign dout = (d == DW'(1)) ? byp : ram_rdata;
`else
   assign dout = ram_rdata;
`endif
endmodule

// File: tb/tb_ram_shift_reg_ctrl.sv
// tb_ram_shift_reg_ctrl: scoreboard bench for the RAM delay-line sequencer with a behavioural RAM.
// Expectations follow SHREG_CTRL_BYPASS_EN when it is defined for the build.
module tb_ram_shift_reg_ctrl;
   localparam int DSIZE = 6;
   localparam int WDEPTH = 10;
   localparam int DW = 4;
`ifdef SHREG_CTRL_BYPASS_EN
   localparam int DMIN = 1;
`else
   localparam int DMIN = 2;
`endif
   logic clk = 0, Reset_n = 0, en = 0, cfg_load = 0;
   logic [DSIZE-1:0] din = '0, ram_wdata, ram_rdata, dout;
   logic [DW-1:0] cfg_delay = '0;
   logic [3:0] ram_waddr, ram_raddr;
   logic ram_we, ram_re, dout_valid, cfg_err, re_q;
   logic [DSIZE-1:0] mem [WDEPTH];
   int ncmp = 0, nfail = 0, cnt = 0;
   int hist[$], exp_q[$];
   int n = 0, first = 0, md = 4, last_exp = 0;
   bit exp_vld = 0, exp_err = 0, run = 0;

   ram_shift_reg_ctrl #(.DSIZE(DSIZE), .WDEPTH(WDEPTH), .DEF_DELAY(4)) dut (
      .clk(clk), .Reset_n(Reset_n), .en(en), .din(din), .cfg_load(cfg_load),
      .cfg_delay(cfg_delay), .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_raddr(ram_raddr),
      .ram_rdata(ram_rdata), .dout(dout), .dout_valid(dout_valid), .cfg_err(cfg_err));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   always @(posedge clk or negedge Reset_n)
      if (!Reset_n) re_q <= 1'b0;
      else re_q <= ram_re;

   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampf(input int dl);
      return (dl > WDEPTH) ? WDEPTH : (dl < DMIN) ? DMIN : dl;
   endfunction

   // Reference: every write goes into hist; an output is valid when its sample
   // index is at or after the first counted write since the last prime.
   task automatic step(input bit e, input bit l, input int dl, input int dv);
      int j;
      @(negedge clk);
      en = e; cfg_load = l; cfg_delay = DW'(dl); din = DSIZE'(dv);
      @(posedge clk);
      exp_err = l && (dl > WDEPTH || dl < DMIN);
      if (e) begin
         hist.push_back(dv & 63);
         n++;
         j = n - md;
         if (!l && j >= first) begin
            exp_q.push_back(hist[j]);
            exp_vld = 1;
         end
      end
      if (l) begin
         md = clampf(dl);
         first = n;
         exp_vld = 0;
      end
   endtask

   task automatic seq(input int k);
      repeat (k) begin step(1, 0, 0, cnt); cnt++; end
   endtask

   task automatic load(input int dl);
      step(1, 1, dl, cnt); cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 0; cfg_load = 0;
      #2 Reset_n = 0;
      #1;
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_waddr", ram_waddr, 0);
      hist.delete(); exp_q.delete();
      n = 0; first = 0; md = 4; exp_vld = 0; exp_err = 0; cnt = 0;
      #100;
      @(negedge clk) Reset_n = 1;
   endtask

   always @(negedge clk)
      if (run && Reset_n) begin
         chk("dout_valid", dout_valid, exp_vld);
         chk("cfg_err", cfg_err, exp_err);
         chk("waddr", ram_waddr, n % WDEPTH);
         chk("raddr", ram_raddr, ((n - md + 1) % WDEPTH + WDEPTH) % WDEPTH);
         if (re_q && dout_valid) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
               last_exp = exp_q.pop_front();
               chk("dout", dout, last_exp);
            end
         end else if (dout_valid) chk("dout_hold", dout, last_exp);
      end

   initial begin
      repeat (2) @(negedge clk);
      chk("init_dout_valid", dout_valid, 0);
      chk("init_cfg_err", cfg_err, 0);
      chk("init_waddr", ram_waddr, 0);
      Reset_n = 1;
      run = 1;
      seq(20);
      load(10);
      seq(40);
      load(15);
      seq(15);
      load(0);
      seq(10);
      load(4);
      seq(10);
      repeat (7) step(0, 0, 0, 0);
      seq(10);
      do_reset();
      seq(12);
      load(1);
      seq(8);
      repeat (400) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
      end
      repeat (2) step(0, 0, 0, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
